// File: rtl/mvm_host_driver_if.sv
// Signal bundle between the MVM host driver, its command/word source, the MVM core and the result sink.
interface mvm_host_driver_if #(
    parameter int B = 8
);
    logic           cmd_valid;
    logic           cmd_ready;
    logic [2:0]     cmd_mode;
    logic           src_valid;
    logic           src_ready;
    logic [B-1:0]   src_data;
    logic           load_matrix;
    logic           load_vector;
    logic           start;
    logic [B-1:0]   data_in;
    logic           done;
    logic [2*B-1:0] data_out;
    logic           res_valid;
    logic           res_ready;
    logic [2*B-1:0] res_data;
    logic           res_last;
    logic           busy;
    logic           err;
    logic [1:0]     err_code;

    modport master (
        input  cmd_valid, cmd_mode, src_valid, src_data, done, data_out, res_ready,
        output cmd_ready, src_ready, load_matrix, load_vector, start, data_in,
               res_valid, res_data, res_last, busy, err, err_code
    );

    modport slave (
        output cmd_valid, cmd_mode, src_valid, src_data, done, data_out, res_ready,
        input  cmd_ready, src_ready, load_matrix, load_vector, start, data_in,
               res_valid, res_data, res_last, busy, err, err_code
    );
endinterface

// File: rtl/mvm_host_driver.sv
// Host-side sequencer for a serial MVM core: streams matrix/vector bursts, starts the core,
// waits for done, captures the K results and drains them on a valid/ready result port.
//
// state     | meaning
// IDLE      | waiting for a command
// LOAD1/2   | load pulse, first word of a burst accepted
// BURST1/2  | remaining words of the burst accepted
// GAP1/2    | last word on data_in, then GAP quiet cycles
// START     | start pulse
// WAIT_DONE | waiting for a rising edge of done, bounded by DONE_TIMEOUT
// CAPTURE   | storing K result words from data_out
// DRAIN     | presenting stored results on the result stream
module mvm_host_driver #(
    parameter int K            = 16,
    parameter int B            = 8,
    parameter int GAP          = 1,
    parameter int DONE_TIMEOUT = 4096
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    mvm_host_driver_if.master mvm
);
    localparam int MAT_N  = K * K;
    localparam int MAX_A  = (DONE_TIMEOUT > MAT_N) ? DONE_TIMEOUT : MAT_N;
    localparam int CNT_MX = (MAX_A > GAP) ? MAX_A : GAP;
    localparam int CW     = $clog2(CNT_MX + 1);
    localparam int IW     = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [3:0] {
        IDLE, LOAD1, BURST1, GAP1, LOAD2, BURST2, GAP2, START, WAIT_DONE, CAPTURE, DRAIN
    } state_t;

    state_t         state_q, state_d;
    logic [2:0]     mode_q, mode_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic           done_q;
    logic           load_m_q, load_v_q, start_q, cmd_ready_q;
    logic           err_q, err_d;
    logic [1:0]     err_code_q, err_code_d;
    logic [B-1:0]   data_in_q, word_d;
    logic [2*B-1:0] res_buf [K];
    logic           capture;
    logic           in_burst, is_load, first_half, cur_mat, two_bursts;
    logic [CW-1:0]  burst_len, remaining;
    state_t         gap_next;

    assign in_burst   = (state_q == LOAD1) || (state_q == BURST1) ||
                        (state_q == LOAD2) || (state_q == BURST2);
    assign is_load    = (state_q == LOAD1) || (state_q == LOAD2);
    assign first_half = (state_q == LOAD1) || (state_q == BURST1);
    // mode bit 0 set (modes 1 and 3) means the matrix goes first
    assign cur_mat    = first_half ? mode_q[0] : !mode_q[0];
    assign two_bursts = (mode_q == 3'd1) || (mode_q == 3'd2);
    assign burst_len  = cur_mat ? CW'(MAT_N) : CW'(K);
    assign remaining  = is_load ? burst_len : cnt_q;
    assign gap_next   = (first_half && two_bursts) ? GAP1 : GAP2;

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        err_d      = 1'b0;
        err_code_d = err_code_q;
        word_d     = '0;
        capture    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cmd_ready_q && mvm.cmd_valid) begin
                    if (mvm.cmd_mode >= 3'd1 && mvm.cmd_mode <= 3'd4) begin
                        mode_d  = mvm.cmd_mode;
                        state_d = LOAD1;
                    end else begin
                        err_d      = 1'b1;
                        err_code_d = 2'd1;
                    end
                end
            end
            LOAD1, BURST1, LOAD2, BURST2: begin
                if (!mvm.src_valid) begin
                    err_d      = 1'b1;
                    err_code_d = 2'd2;
                    state_d    = IDLE;
                    cnt_d      = '0;
                end else begin
                    word_d = mvm.src_data;
                    if (remaining == CW'(1)) begin
                        state_d = gap_next;
                        cnt_d   = CW'(GAP);
                    end else if (is_load) begin
                        state_d = (state_q == LOAD1) ? BURST1 : BURST2;
                        cnt_d   = burst_len - CW'(1);
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
            end
            GAP1, GAP2: begin
                if (cnt_q == '0) begin
                    state_d = (state_q == GAP1) ? LOAD2 : START;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            START: begin
                state_d = WAIT_DONE;
                cnt_d   = CW'(DONE_TIMEOUT - 1);
            end
            WAIT_DONE: begin
                if (mvm.done && !done_q) begin
                    state_d = CAPTURE;
                    idx_d   = '0;
                end else if (cnt_q == '0) begin
                    err_d      = 1'b1;
                    err_code_d = 2'd3;
                    state_d    = IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            CAPTURE: begin
                capture = 1'b1;
                if (idx_q == IW'(K - 1)) begin
                    state_d = DRAIN;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            DRAIN: begin
                if (mvm.res_ready) begin
                    if (idx_q == IW'(K - 1)) begin
                        state_d = IDLE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // MVM-side strobes are registered from the next state so they line up with the state itself
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            mode_q      <= '0;
            cnt_q       <= '0;
            idx_q       <= '0;
            done_q      <= 1'b0;
            load_m_q    <= 1'b0;
            load_v_q    <= 1'b0;
            start_q     <= 1'b0;
            data_in_q   <= '0;
            cmd_ready_q <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            done_q      <= mvm.done;
            load_m_q    <= (state_d == LOAD1 && mode_d[0]) || (state_d == LOAD2 && !mode_d[0]);
            load_v_q    <= (state_d == LOAD1 && !mode_d[0]) || (state_d == LOAD2 && mode_d[0]);
            start_q     <= (state_d == START);
            data_in_q   <= word_d;
            cmd_ready_q <= (state_d == IDLE);
            err_q       <= err_d;
            err_code_q  <= err_code_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (capture) begin
            res_buf[idx_q] <= mvm.data_out;
        end
    end

    assign mvm.cmd_ready   = cmd_ready_q;
    assign mvm.src_ready   = in_burst;
    assign mvm.load_matrix = load_m_q;
    assign mvm.load_vector = load_v_q;
    assign mvm.start       = start_q;
    assign mvm.data_in     = data_in_q;
    assign mvm.res_valid   = (state_q == DRAIN);
    assign mvm.res_data    = (state_q == DRAIN) ? res_buf[idx_q] : '0;
    assign mvm.res_last    = (state_q == DRAIN) && (idx_q == IW'(K - 1));
    assign mvm.busy        = (state_q != IDLE);
    assign mvm.err         = err_q;
    assign mvm.err_code    = err_code_q;
endmodule

// File: tb/tb_mvm_host_driver.sv
// Directed bench for mvm_host_driver: command modes, burst framing, gaps, error paths,
// result stream back-pressure and asynchronous reset.
`timescale 1ns/1ps
module tb_mvm_host_driver;
    localparam int K   = 16;
    localparam int B   = 8;
    localparam int GAP = 1;
    localparam int TMO = 4096;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    mvm_host_driver_if #(.B(B)) m ();

    mvm_host_driver #(.K(K), .B(B), .GAP(GAP), .DONE_TIMEOUT(TMO)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .mvm    (m)
    );

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int pseq, rem, stray, overlap, nerr, last_pos, nlast, unstable;
    int pcyc[$];
    logic [B-1:0]   words[$];
    logic [2*B-1:0] res_q[$];
    logic [1:0]     last_code;
    logic           stall_prev = 1'b0;
    logic [2*B-1:0] prev_data = '0;
    int src_word = 0;
    int drop_at = -1;
    bit tog = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    function automatic logic [2*B-1:0] rv(input int s, input int i);
        return 16'(32'h8000 + s * 4099 + i * 313);
    endfunction

    task automatic clear();
        pseq = 0; rem = 0; stray = 0; overlap = 0; nerr = 0;
        last_pos = -1; nlast = 0; unstable = 0; last_code = '0;
        pcyc.delete(); words.delete(); res_q.delete();
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (int'(m.load_matrix) + int'(m.load_vector) + int'(m.start) > 1) overlap++;
            if (rem > 0) begin
                words.push_back(m.data_in);
                rem--;
            end else if (m.data_in != '0) begin
                stray++;
            end
            if (m.load_matrix) begin pseq = pseq * 4 + 1; pcyc.push_back(cyc); rem = K * K; end
            if (m.load_vector) begin pseq = pseq * 4 + 2; pcyc.push_back(cyc); rem = K; end
            if (m.start)       begin pseq = pseq * 4 + 3; pcyc.push_back(cyc); end
            if (m.err) begin nerr++; last_code = m.err_code; end
            if (m.res_valid) begin
                if (stall_prev && m.res_data != prev_data) unstable++;
                if (m.res_ready) begin
                    if (m.res_last) begin last_pos = res_q.size(); nlast++; end
                    res_q.push_back(m.res_data);
                end
            end
            stall_prev = m.res_valid && !m.res_ready;
            prev_data  = m.res_data;
        end
    end

    // word source: counts accepted words, optionally withholds valid at word drop_at
    initial begin
        logic acc;
        m.src_valid = 1'b0;
        m.src_data  = '0;
        forever begin
            @(negedge clk);
            acc = m.src_valid & m.src_ready;
            @(posedge clk);
            #1;
            if (acc) src_word++;
            m.src_data  = src_word[B-1:0];
            m.src_valid = (src_word != drop_at);
        end
    end

    initial begin
        m.res_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1 m.res_ready = tog ? ~m.res_ready : 1'b1;
        end
    end

    task automatic do_cmd(input logic [2:0] mode);
        @(posedge clk); #1;
        m.cmd_valid = 1'b1;
        m.cmd_mode  = mode;
        @(posedge clk); #1;
        m.cmd_valid = 1'b0;
        m.cmd_mode  = 3'd0;
    endtask

    task automatic run_normal(input logic [2:0] mode, input bit toggle, input int seed,
                              input int exp_seq);
        int n1, n2, n, bad;
        n1 = mode[0] ? K * K : K;
        n2 = (mode == 3'd1) ? K : (mode == 3'd2) ? K * K : 0;
        clear();
        src_word = 0;
        drop_at  = -1;
        tog      = toggle;
        do_cmd(mode);
        n = 0;
        while (!m.start && n < 1000) begin @(negedge clk); n++; end
        chk("start_seen", m.start, 1);
        repeat (3) @(posedge clk);
        #1 m.done = 1'b1;
        for (int i = 0; i < K; i++) begin
            @(posedge clk);
            #1 m.data_out = rv(seed, i);
        end
        @(posedge clk); #1;
        m.data_out = '0;
        m.done     = 1'b0;
        n = 0;
        while (res_q.size() < K && n < 200) begin @(negedge clk); n++; end
        @(negedge clk);
        tog = 1'b0;
        chk("pulse_seq", pseq, exp_seq);
        chk("pulse_gap1", (pcyc.size() > 1) ? pcyc[1] - pcyc[0] : -1, n1 + GAP + 1);
        if (n2 > 0) chk("pulse_gap2", (pcyc.size() > 2) ? pcyc[2] - pcyc[1] : -1, n2 + GAP + 1);
        chk("word_cnt", words.size(), n1 + n2);
        bad = 0;
        for (int i = 0; i < words.size(); i++) if (words[i] !== 8'(i)) bad++;
        chk("word_vals", bad, 0);
        chk("stray_data", stray, 0);
        chk("overlap", overlap, 0);
        chk("res_cnt", res_q.size(), K);
        for (int i = 0; i < K; i++)
            chk($sformatf("res%0d", i), (res_q.size() > i) ? res_q[i] : 'x, rv(seed, i));
        chk("last_pos", last_pos, K - 1);
        chk("last_cnt", nlast, 1);
        chk("stable", unstable, 0);
        chk("no_err", nerr, 0);
        chk("idle_after", {m.busy, m.cmd_ready}, 2'b01);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        m.cmd_valid = 1'b0;
        m.cmd_mode  = 3'd0;
        m.done      = 1'b0;
        m.data_out  = '0;
        clear();
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_outs", {m.load_matrix, m.load_vector, m.start, m.data_in, m.src_ready,
                         m.cmd_ready, m.busy, m.err, m.err_code, m.res_valid, m.res_last,
                         m.res_data}, 64'd0);
        rst_n = 1'b1;
        #1 chk("rdy_before_edge", m.cmd_ready, 0);
        @(negedge clk);
        chk("rdy_after_edge", m.cmd_ready, 1);

        run_normal(3'd1, 1'b0, 1, 27);
        run_normal(3'd2, 1'b1, 2, 39);
        run_normal(3'd4, 1'b0, 3, 11);

        clear();
        do_cmd(3'd5);
        repeat (3) @(negedge clk);
        chk("ill_err_cnt", nerr, 1);
        chk("ill_code", last_code, 2'd1);
        chk("ill_pulses", pseq, 0);
        chk("ill_idle", {m.busy, m.cmd_ready}, 2'b01);

        clear();
        src_word = 0;
        drop_at  = 100;
        do_cmd(3'd1);
        n = 0;
        while (!m.err && n < 600) begin @(negedge clk); n++; end
        chk("urun_err", m.err, 1);
        chk("urun_code", m.err_code, 2'd2);
        chk("urun_idle", {m.busy, m.cmd_ready, m.src_ready}, 3'b010);
        drop_at = -1;
        repeat (5) @(negedge clk);
        chk("urun_seq", pseq, 1);
        chk("urun_w99", (words.size() > 99) ? words[99] : 'x, 8'd99);

        clear();
        src_word = 0;
        do_cmd(3'd3);
        n = 0;
        while (!m.start && n < 1000) begin @(negedge clk); n++; end
        chk("tmo_start", m.start, 1);
        n = 0;
        do begin @(negedge clk); n++; end while (!m.err && n < TMO + 100);
        chk("tmo_cycles", n, TMO + 1);
        chk("tmo_code", m.err_code, 2'd3);
        chk("tmo_seq", pseq, 7);
        @(negedge clk);
        chk("tmo_pulse", {m.err, m.err_code}, 3'b011);
        chk("tmo_idle", {m.busy, m.cmd_ready}, 2'b01);

        clear();
        src_word = 0;
        do_cmd(3'd1);
        n = 0;
        while (!m.load_vector && n < 600) begin @(negedge clk); n++; end
        chk("mid_lv_seen", m.load_vector, 1);
        repeat (5) @(negedge clk);
        chk("mid_busy", {m.busy, m.src_ready}, 2'b11);
        #2 rst_n = 1'b0;
        #1 chk("mid_rst_outs", {m.load_matrix, m.load_vector, m.start, m.data_in, m.src_ready,
                                m.cmd_ready, m.busy, m.err, m.err_code, m.res_valid,
                                m.res_last, m.res_data}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rdy", m.cmd_ready, 1);
        run_normal(3'd4, 1'b1, 7, 11);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
